// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin pick function for fifo_wr_arbiter.
// The pick function is sized for the largest supported requester count.
package fifo_arb_pkg;

  localparam int MAX_NREQ = 16;
  localparam int PTR_W    = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [PTR_W-1:0] idx;
    logic             vld;
  } rr_pick_t;

  // Position k is (ptr + k) mod nreq; the lowest k with a request wins.
  function automatic rr_pick_t rr_pick_fn(input logic [MAX_NREQ-1:0] req,
                                          input logic [PTR_W-1:0]    ptr,
                                          input logic [PTR_W:0]      nreq);
    rr_pick_t         pick;
    logic [PTR_W:0]   pos;
    pick = '0;
    for (int k = MAX_NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (PTR_W+1)'(k);
      if (pos >= nreq) pos = pos - nreq;
      if ((k < int'(nreq)) && req[pos[PTR_W-1:0]]) begin
        pick.idx = pos[PTR_W-1:0];
        pick.vld = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate requests from rr_ptr, priority-encode,
// and map the winner back to an absolute requester index.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [IDW-1:0]  gnt_idx,
  output logic            gnt_vld
);

  rr_pick_t pick;

  always_comb begin
    pick    = rr_pick_fn(MAX_NREQ'(req), PTR_W'(rr_ptr), (PTR_W+1)'(NREQ));
    gnt_idx = IDW'(pick.idx);
    gnt_vld = pick.vld;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NREQ requesters.
// Build with FIFO_ARB_PKT_EN to enable packet lock with MAX_BURST forced release.
//
// state    | meaning
// ARB_IDLE | per-beat round-robin from rr_ptr
// ARB_LOCK | only the packet owner may write until last or MAX_BURST beats
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 16,
  parameter int IDW       = $clog2(NREQ)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       last,
  input  logic [NREQ*DSIZE-1:0] din,
  output logic [NREQ-1:0]       ack,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic [IDW-1:0]        wsrc,
  output logic                  locked,
  output logic                  ovf_err
);

  localparam int             CNTW     = $clog2(MAX_BURST + 1);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);

  // Explicit wrap so non-power-of-two NREQ never lands on an unused index.
  function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] i);
    return (i == LAST_IDX) ? '0 : i + 1'b1;
  endfunction

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] pick_idx, gnt_idx, sel_idx;
  logic           pick_vld, gnt_vld, accept;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
    .req     (req),
    .rr_ptr  (rr_ptr_q),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

`ifdef FIFO_ARB_PKT_EN
  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [CNTW-1:0] cnt_q, cnt_d, cnt_inc;
  logic           ovf_q, ovf_d, burst_done;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    ovf_d      = 1'b0;
    rr_ptr_d   = rr_ptr_q;
    cnt_inc    = cnt_q + 1'b1;
    burst_done = (cnt_inc == CNTW'(MAX_BURST));
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          rr_ptr_d = wrap_inc(gnt_idx);
          if (!last[gnt_idx]) begin
            if (MAX_BURST <= 1) begin
              ovf_d = 1'b1;
            end else begin
              state_d = ARB_LOCK;
              owner_d = gnt_idx;
              cnt_d   = CNTW'(1);
            end
          end
        end
      end
      ARB_LOCK: begin
        if (accept) begin
          if (last[owner_q] || burst_done) begin
            state_d  = ARB_IDLE;
            cnt_d    = '0;
            rr_ptr_d = wrap_inc(owner_q);
            ovf_d    = burst_done & ~last[owner_q];
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    if (state_q == ARB_LOCK) begin
      gnt_idx = owner_q;
      gnt_vld = req[owner_q];
    end else begin
      gnt_idx = pick_idx;
      gnt_vld = pick_vld;
    end
    locked  = (state_q == ARB_LOCK);
    ovf_err = ovf_q;
  end
`else
  logic unused_pkt;
  assign unused_pkt = ^{last, CNTW[0]};

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) rr_ptr_q <= '0;
    else      rr_ptr_q <= rr_ptr_d;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = wrap_inc(gnt_idx);
    gnt_idx = pick_idx;
    gnt_vld = pick_vld;
    locked  = 1'b0;
    ovf_err = 1'b0;
  end
`endif

  // Reset gates acceptance so nothing is written while wrst is high.
  always_comb begin
    accept  = gnt_vld & ~wfull & ~wrst;
    ack     = '0;
    if (accept) ack[gnt_idx] = 1'b1;
    winc    = accept;
    sel_idx = accept ? gnt_idx : '0;
    wdata   = din[sel_idx*DSIZE +: DSIZE];
    wsrc    = sel_idx;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a per-cycle expectation queue.
module tb_fifo_wr_arbiter;

  logic        wclk = 1'b0;
  logic        wrst;
  logic [3:0]  req, last, ack;
  logic [31:0] din;
  logic        wfull, winc, locked, ovf_err;
  logic [7:0]  wdata;
  logic [1:0]  wsrc;

  int passed  = 0;
  int total   = 0;
  int beat_no = 0;

  typedef struct {
    logic [3:0] ack;
    logic [1:0] src;
    logic [7:0] data;
    logic       lk;
    logic       ovf;
  } exp_t;

  exp_t exp_q[$];

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.NREQ(4), .DSIZE(8), .MAX_BURST(16)) dut (
    .wclk    (wclk),
    .wrst    (wrst),
    .req     (req),
    .last    (last),
    .din     (din),
    .ack     (ack),
    .wfull   (wfull),
    .winc    (winc),
    .wdata   (wdata),
    .wsrc    (wsrc),
    .locked  (locked),
    .ovf_err (ovf_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of stimulus, queue what it should produce, then check it.
  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic f,
                      input logic [3:0] eack, input logic elk, input logic eovf);
    exp_t e;
    beat_no++;
    req   = r;
    last  = l;
    wfull = f;
    for (int i = 0; i < 4; i++) din[i*8 +: 8] = {i[1:0], beat_no[5:0]};
    e.ack = eack;
    e.src = 2'd0;
    for (int i = 0; i < 4; i++) if (eack[i]) e.src = i[1:0];
    e.data = {e.src, beat_no[5:0]};
    e.lk   = elk;
    e.ovf  = eovf;
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    chk($sformatf("ack@%0d", beat_no), 32'(ack), 32'(e.ack));
    chk($sformatf("winc@%0d", beat_no), 32'(winc), 32'(|e.ack));
    if (winc) begin
      chk($sformatf("wsrc@%0d", beat_no), 32'(wsrc), 32'(e.src));
      chk($sformatf("wdata@%0d", beat_no), 32'(wdata), 32'(e.data));
    end
    chk($sformatf("locked@%0d", beat_no), 32'(locked), 32'(e.lk));
    chk($sformatf("ovf_err@%0d", beat_no), 32'(ovf_err), 32'(e.ovf));
    @(posedge wclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    wrst  = 1'b1;
    req   = 4'hF;
    last  = 4'h0;
    wfull = 1'b0;
    din   = '0;
    #12;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_winc", 32'(winc), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_ovf", 32'(ovf_err), 32'h0);
    wrst = 1'b0;

    // Round-robin from requester 0 with everyone requesting single beats.
    step(4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 1'b0);
    step(4'hF, 4'hF, 1'b0, 4'b0010, 1'b0, 1'b0);
    step(4'hF, 4'hF, 1'b0, 4'b0100, 1'b0, 1'b0);
    step(4'hF, 4'hF, 1'b0, 4'b1000, 1'b0, 1'b0);
    step(4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 1'b0);

    // Full stall holds everything; release accepts in the same cycle.
    for (int i = 0; i < 3; i++) step(4'b0100, 4'hF, 1'b1, 4'b0000, 1'b0, 1'b0);
    step(4'b0100, 4'hF, 1'b0, 4'b0100, 1'b0, 1'b0);
    step(4'b1011, 4'hF, 1'b0, 4'b1000, 1'b0, 1'b0);

`ifdef FIFO_ARB_PKT_EN
    // Three-beat packet from requester 0 while requester 1 waits.
    step(4'b0011, 4'b0010, 1'b0, 4'b0001, 1'b0, 1'b0);
    step(4'b0011, 4'b0010, 1'b0, 4'b0001, 1'b1, 1'b0);
    step(4'b0011, 4'b0011, 1'b0, 4'b0001, 1'b1, 1'b0);
    step(4'b0011, 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0);

    // Owner 3 bubbles for two cycles while requester 2 is ignored.
    step(4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);
    step(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    step(4'b1100, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0);
    step(4'b1100, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b0);
    step(4'b0100, 4'hF,    1'b0, 4'b0100, 1'b0, 1'b0);

    // Requester 3 streams without last: 16 beats then forced release to 0.
    step(4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b0);
    step(4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b1);
    step(4'b1001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b0);
`else
    // Per-beat round-robin ignores last.
    step(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0);
    step(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0);
    step(4'b0011, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0);
    step(4'b0011, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0);
    step(4'b1111, 4'b0000, 1'b0, 4'b0100, 1'b0, 1'b0);
`endif

    // Asynchronous reset between edges, then arbitration restarts at 0.
    #2;
    wrst = 1'b1;
    #1;
    chk("arst_locked", 32'(locked), 32'h0);
    chk("arst_winc", 32'(winc), 32'h0);
    chk("arst_ack", 32'(ack), 32'h0);
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    step(4'hF, 4'hF, 1'b0, 4'b0001, 1'b0, 1'b0);
    step(4'hF, 4'hF, 1'b0, 4'b0010, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
